// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: handshake, hazard and pipeline-control signals between the LC-3b datapath and its sequencer
interface pipeline_hazard_ctrl_if;
  logic imem_read, imem_resp, dmem_req, dmem_resp;
  logic [2:0] id_src1, id_src2, ex_dest;
  logic id_use_src1, id_use_src2, ex_mem_read, mem_redirect;
  logic load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
  logic clr_if_id, clr_id_ex, clr_ex_mem, imem_discard;
  modport master (
    output imem_read, imem_resp, dmem_req, dmem_resp, id_src1, id_src2, ex_dest,
           id_use_src1, id_use_src2, ex_mem_read, mem_redirect,
    input  load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
           clr_if_id, clr_id_ex, clr_ex_mem, imem_discard
  );
  modport slave (
    input  imem_read, imem_resp, dmem_req, dmem_resp, id_src1, id_src2, ex_dest,
           id_use_src1, id_use_src2, ex_mem_read, mem_redirect,
    output load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
           clr_if_id, clr_id_ex, clr_ex_mem, imem_discard
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: LC-3b five-stage load/hold/bubble sequencer; HAZARD_PERF_CNT_EN adds stall/flush counters
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic clk,
  input  logic reset,
  pipeline_hazard_ctrl_if.slave hz,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);
  typedef enum logic {RUN, DRAIN} state_t;
  state_t state;
  logic imem_busy, dmem_busy, load_use, redirect, fe_stall;
  always_comb begin
    imem_busy = hz.imem_read & ~hz.imem_resp;
    dmem_busy = hz.dmem_req & ~hz.dmem_resp;
    load_use  = hz.ex_mem_read & ((hz.id_use_src1 & (hz.id_src1 == hz.ex_dest)) |
                                  (hz.id_use_src2 & (hz.id_src2 == hz.ex_dest)));
    redirect  = ~reset & ~dmem_busy & hz.mem_redirect;
    // DRAIN, load-use and an outstanding fetch all hold the front end and bubble ID/EX
    fe_stall  = ~reset & ~dmem_busy & ~hz.mem_redirect & ((state == DRAIN) | load_use | imem_busy);
    hz.load_pc      = ~reset & ~dmem_busy & ~fe_stall;
    hz.load_if_id   = hz.load_pc;
    hz.load_id_ex   = ~reset & ~dmem_busy;
    hz.load_ex_mem  = hz.load_id_ex;
    hz.load_mem_wb  = hz.load_id_ex;
    hz.clr_if_id    = reset | redirect;
    hz.clr_id_ex    = reset | redirect | fe_stall;
    hz.clr_ex_mem   = reset | redirect;
    hz.imem_discard = ~reset & (state == DRAIN) & hz.imem_resp;
  end
  always_ff @(posedge clk)
    if (reset) state <= RUN;
    else if (state == RUN) state <= (redirect & imem_busy) ? DRAIN : RUN;
    else state <= hz.imem_resp ? RUN : DRAIN;
`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk)
    if (reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!hz.load_pc && !(&stall_cycles)) stall_cycles <= stall_cycles + CNT_W'(1);
      if (redirect && !(&flush_count)) flush_count <= flush_count + CNT_W'(1);
    end
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: scoreboard bench for the pipeline hazard sequencer
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0;
  logic reset;
  logic [31:0] stall_cycles, flush_count;
  always #5 clk = ~clk;
  pipeline_hazard_ctrl_if hz();
  pipeline_hazard_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .hz(hz.slave),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );
  // {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, clr_if_id, clr_id_ex, clr_ex_mem, imem_discard}
  wire [8:0] obs = {hz.load_pc, hz.load_if_id, hz.load_id_ex, hz.load_ex_mem, hz.load_mem_wb,
                    hz.clr_if_id, hz.clr_id_ex, hz.clr_ex_mem, hz.imem_discard};
  localparam logic [8:0] RST    = 9'b00000_111_0;
  localparam logic [8:0] NORM   = 9'b11111_000_0;
  localparam logic [8:0] FREEZE = 9'b00000_000_0;
  localparam logic [8:0] FLUSH  = 9'b11111_111_0;
  localparam logic [8:0] STALL  = 9'b00111_010_0;
  localparam logic [8:0] DISC   = 9'b00111_010_1;
  localparam logic [11:0] IDLE  = 12'h000;
  logic [8:0] exp_q[$];
  int checks = 0, failures = 0;
  int m_stall = 0, m_flush = 0;
  // c = {reset, imem_read, imem_resp, dmem_req, dmem_resp, mem_redirect}
  // lu = {ex_mem_read, ex_dest, id_src1, id_use_src1, id_src2, id_use_src2}
  task automatic apply(input logic [5:0] c, input logic [11:0] lu, input logic [8:0] e);
    @(negedge clk);
    {reset, hz.imem_read, hz.imem_resp, hz.dmem_req, hz.dmem_resp, hz.mem_redirect} = c;
    {hz.ex_mem_read, hz.ex_dest, hz.id_src1, hz.id_use_src1, hz.id_src2, hz.id_use_src2} = lu;
    exp_q.push_back(e);
    if (c[5]) begin
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (!e[8]) m_stall++;
      if (e[1]) m_flush++;
    end
    #2;
  endtask
  task automatic test_reset;
    logic [8:0] e;
    for (int i = 0; i < 4; i++) begin
      apply(i < 3 ? 6'b100000 : 6'b000000, IDLE, i < 3 ? RST : NORM);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL reset[%0d] got=%b exp=%b", i, obs, e);
      end
    end
    checks++;
    if (stall_cycles !== 32'd0 || flush_count !== 32'd0) begin
      failures++;
      $display("FAIL reset_counters got=%0d/%0d exp=0/0", stall_cycles, flush_count);
    end
  endtask
  task automatic test_load_use;
    logic [5:0]  c[$] = '{6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b010000, 6'b000001, 6'b000000};
    logic [11:0] l[$] = '{{1'b1, 3'd3, 3'd3, 1'b1, 3'd0, 1'b0}, IDLE,
                          {1'b1, 3'd5, 3'd1, 1'b1, 3'd5, 1'b1}, IDLE,
                          {1'b1, 3'd3, 3'd3, 1'b0, 3'd3, 1'b0},
                          {1'b0, 3'd3, 3'd3, 1'b1, 3'd3, 1'b1},
                          {1'b1, 3'd2, 3'd2, 1'b1, 3'd0, 1'b0},
                          {1'b1, 3'd2, 3'd2, 1'b1, 3'd0, 1'b0}, IDLE};
    logic [8:0]  x[$] = '{STALL, NORM, STALL, NORM, NORM, NORM, STALL, FLUSH, NORM};
    logic [8:0] e;
    for (int i = 0; i < c.size(); i++) begin
      apply(c[i], l[i], x[i]);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL load_use[%0d] got=%b exp=%b", i, obs, e);
      end
    end
  endtask
  task automatic test_imem_stall;
    logic [5:0] c[$] = '{6'b010000, 6'b010000, 6'b011000, 6'b000000};
    logic [8:0] x[$] = '{STALL, STALL, NORM, NORM};
    logic [8:0] e;
    for (int i = 0; i < c.size(); i++) begin
      apply(c[i], IDLE, x[i]);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL imem_stall[%0d] got=%b exp=%b", i, obs, e);
      end
    end
  endtask
  task automatic test_dmem_freeze;
    logic [5:0]  c[$] = '{6'b000100, 6'b000101, 6'b000101, 6'b000111, 6'b000000, 6'b010100, 6'b000000};
    logic [11:0] l[$] = '{IDLE, IDLE, IDLE, IDLE, IDLE, {1'b1, 3'd4, 3'd4, 1'b1, 3'd0, 1'b0}, IDLE};
    logic [8:0]  x[$] = '{FREEZE, FREEZE, FREEZE, FLUSH, NORM, FREEZE, NORM};
    logic [8:0] e;
    for (int i = 0; i < c.size(); i++) begin
      apply(c[i], l[i], x[i]);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL dmem_freeze[%0d] got=%b exp=%b", i, obs, e);
      end
    end
  endtask
  task automatic test_drain;
    logic [5:0] c[$] = '{6'b010001, 6'b010000, 6'b010100, 6'b011000, 6'b000000,
                         6'b010001, 6'b010001, 6'b011000, 6'b000000};
    logic [8:0] x[$] = '{FLUSH, STALL, FREEZE, DISC, NORM, FLUSH, FLUSH, DISC, NORM};
    logic [8:0] e;
    for (int i = 0; i < c.size(); i++) begin
      apply(c[i], IDLE, x[i]);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL drain[%0d] got=%b exp=%b", i, obs, e);
      end
    end
  endtask
  task automatic test_redirect_resp;
    logic [5:0] c[$] = '{6'b011001, 6'b000000, 6'b011000};
    logic [8:0] x[$] = '{FLUSH, NORM, NORM};
    logic [8:0] e;
    for (int i = 0; i < c.size(); i++) begin
      apply(c[i], IDLE, x[i]);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL redirect_resp[%0d] got=%b exp=%b", i, obs, e);
      end
    end
  endtask
  task automatic test_reset_mid_drain;
    logic [5:0] c[$] = '{6'b010001, 6'b010000, 6'b111000, 6'b000000, 6'b011000};
    logic [8:0] x[$] = '{FLUSH, STALL, RST, NORM, NORM};
    logic [8:0] e;
    for (int i = 0; i < c.size(); i++) begin
      apply(c[i], IDLE, x[i]);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL reset_mid_drain[%0d] got=%b exp=%b", i, obs, e);
      end
    end
  endtask
  task automatic test_counters;
    logic [5:0]  c[$] = '{6'b100000, 6'b000001, 6'b000000, 6'b000000, 6'b000000, 6'b000001, 6'b000000};
    logic [11:0] l[$] = '{IDLE, IDLE, IDLE, {1'b1, 3'd7, 3'd7, 1'b1, 3'd0, 1'b0}, IDLE, IDLE, IDLE};
    logic [8:0]  x[$] = '{RST, FLUSH, NORM, STALL, NORM, FLUSH, NORM};
    logic [8:0] e;
    logic [31:0] es, ef;
    for (int i = 0; i < c.size(); i++) begin
      apply(c[i], l[i], x[i]);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL counters_seq[%0d] got=%b exp=%b", i, obs, e);
      end
    end
    @(negedge clk);
`ifdef HAZARD_PERF_CNT_EN
    es = 32'd1;
    ef = 32'd2;
`else
    es = 32'd0;
    ef = 32'd0;
`endif
    checks++;
    if (stall_cycles !== es || flush_count !== ef) begin
      failures++;
      $display("FAIL counters got=%0d/%0d exp=%0d/%0d", stall_cycles, flush_count, es, ef);
    end
  endtask
  task automatic test_counter_model;
    logic [8:0] x[$] = '{STALL, FREEZE, DISC, NORM};
    logic [5:0] c[$] = '{6'b010001, 6'b010000, 6'b010100, 6'b011000, 6'b000000};
    logic [8:0] e;
    logic [31:0] es, ef;
    x.push_front(FLUSH);
    for (int i = 0; i < c.size(); i++) begin
      apply(c[i], IDLE, x[i]);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL counter_model_seq[%0d] got=%b exp=%b", i, obs, e);
      end
    end
    @(negedge clk);
`ifdef HAZARD_PERF_CNT_EN
    es = 32'(m_stall);
    ef = 32'(m_flush);
`else
    es = 32'd0;
    ef = 32'd0;
`endif
    checks++;
    if (stall_cycles !== es || flush_count !== ef) begin
      failures++;
      $display("FAIL counter_model got=%0d/%0d exp=%0d/%0d", stall_cycles, flush_count, es, ef);
    end
  endtask
  initial begin
    reset = 1'b1;
    {hz.imem_read, hz.imem_resp, hz.dmem_req, hz.dmem_resp, hz.mem_redirect} = '0;
    {hz.ex_mem_read, hz.ex_dest, hz.id_src1, hz.id_use_src1, hz.id_src2, hz.id_use_src2} = '0;
    test_reset();
    test_load_use();
    test_imem_stall();
    test_dmem_freeze();
    test_drain();
    test_redirect_resp();
    test_reset_mid_drain();
    test_counters();
    test_counter_model();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
